rx_frame_parser: RTL

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

---
 rtl/rx_frame_pkg.sv | 32 +++
 rtl/rx_frame_buf.sv | 35 +++
 rtl/rx_frame_parser.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_pkg.sv
// ---------------------------------------------------------------------------
// rx_frame_pkg
// Shared definitions for the UART frame parser: FSM state encoding, the
// default frame start marker and the byte offsets of each frame field.
// Frame layout: SYNC, CMD, LEN, LEN payload bytes, CHK
// (CHK = XOR of CMD, LEN and every payload byte).
// ---------------------------------------------------------------------------
package rx_frame_pkg;

  // Parser state encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  // Default frame start marker
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Byte offsets of the fields inside a frame
  localparam int OFF_SYNC = 0;
  localparam int OFF_CMD  = 1;
  localparam int OFF_LEN  = 2;
  localparam int OFF_PAY  = 3;

  // Offset of the CHK byte for a frame carrying len payload bytes
  function automatic int chk_offset(input int len);
    return OFF_PAY + len;
  endfunction

endpackage

// File: rtl/rx_frame_buf.sv
// ---------------------------------------------------------------------------
// rx_frame_buf
// Payload storage for one frame: DEPTH x 8 bits, one synchronous write port
// and one combinational read port. Contents are not reset.
// Ports:
//   clk    - system clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
// ---------------------------------------------------------------------------
module rx_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_frame_parser.sv
// ---------------------------------------------------------------------------
// rx_frame_parser
// Parses SYNC/CMD/LEN/payload/CHK frames from a UART byte stream, buffers
// the payload and, once the checksum matches, streams it out as
// valid/ready beats.
// Ports:
//   clk, resetn                 - clock, synchronous active-low reset
//   uart_rx_valid/data/break    - received byte stream (one-cycle pulses)
//   out_valid/ready/data/last   - payload beat stream
//   out_cmd, out_len            - CMD and LEN of the frame being output
//   err_chk, err_len, err_timeout - one-cycle error pulses
//   err_overrun                 - sticky: byte arrived while outputting
// ---------------------------------------------------------------------------
module rx_frame_parser
  import rx_frame_pkg::*;
#(
  parameter int         CLK_HZ         = 50_000_000,
  parameter int         MAX_PAYLOAD    = 16,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 104_167
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx_valid,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_break,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] out_cmd,
  output logic [7:0] out_len,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW  = $clog2(MAX_PAYLOAD + 1);
  localparam int BAW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  logic [2:0]    state;
  logic [7:0]    cmd_q;
  logic [7:0]    len_q;
  logic [7:0]    checksum;
  logic [IW-1:0] idx;
  logic [IW-1:0] rd_idx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    buf_rdata;

  logic in_frame;
  logic abort;
  logic timeout_hit;
  logic beat_fire;
  logic len_zero;

  // States in which the inter-byte timeout is armed
  assign in_frame = (state == S_CMD) || (state == S_LEN) ||
                    (state == S_PAY) || (state == S_CHK);

  // A BREAK aborts the frame everywhere except while outputting
  assign abort = uart_rx_valid && uart_rx_break && (state != S_OUT);

  // A byte in the same cycle always wins over the timeout
  assign timeout_hit = in_frame && !uart_rx_valid &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign len_zero  = (len_q == 8'd0);
  assign out_valid = (state == S_OUT);
  assign beat_fire = out_valid && out_ready;

  // Zero-length frames emit a single 0x00 beat; outputs are forced to 0
  // outside S_OUT so they read 0 in and after reset
  assign out_data = (out_valid && !len_zero) ? buf_rdata : 8'h00;
  assign out_last = out_valid && (len_zero || (8'(rd_idx) == len_q - 8'd1));
  assign out_cmd  = cmd_q;
  assign out_len  = len_q;

  rx_frame_buf #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (BAW)
  ) u_buf (
    .clk   (clk),
    .we    ((state == S_PAY) && uart_rx_valid && !uart_rx_break),
    .waddr (idx[BAW-1:0]),
    .wdata (uart_rx_data),
    .raddr (rd_idx[BAW-1:0]),
    .rdata (buf_rdata)
  );

  // Inter-byte timeout counter, held at 0 outside the frame-receive states
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_cnt <= '0;
    end else if (in_frame && !uart_rx_valid && !timeout_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cmd_q       <= 8'h00;
      len_q       <= 8'h00;
      checksum    <= 8'h00;
      idx         <= '0;
      rd_idx      <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        idx   <= '0;
      end else if (timeout_hit) begin
        err_timeout <= 1'b1;
        state       <= S_IDLE;
        idx         <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (uart_rx_valid && uart_rx_data == SYNC_BYTE) begin
              state <= S_CMD;
            end
          end
          S_CMD: begin
            if (uart_rx_valid) begin
              cmd_q    <= uart_rx_data;
              checksum <= uart_rx_data;
              state    <= S_LEN;
            end
          end
          S_LEN: begin
            if (uart_rx_valid) begin
              len_q    <= uart_rx_data;
              checksum <= checksum ^ uart_rx_data;
              idx      <= '0;
              if (uart_rx_data > 8'(MAX_PAYLOAD)) begin
                err_len <= 1'b1;
                state   <= S_IDLE;
              end else if (uart_rx_data == 8'd0) begin
                state <= S_CHK;
              end else begin
                state <= S_PAY;
              end
            end
          end
          S_PAY: begin
            if (uart_rx_valid) begin
              checksum <= checksum ^ uart_rx_data;
              idx      <= idx + 1'b1;
              if (8'(idx) == len_q - 8'd1) begin
                state <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (uart_rx_valid) begin
              if (uart_rx_data == checksum) begin
                rd_idx <= '0;
                state  <= S_OUT;
              end else begin
                err_chk <= 1'b1;
                state   <= S_IDLE;
              end
            end
          end
          S_OUT: begin
            // Bytes cannot be accepted while the buffer is being drained
            if (uart_rx_valid) begin
              err_overrun <= 1'b1;
            end
            if (beat_fire) begin
              if (out_last) begin
                rd_idx <= '0;
                idx    <= '0;
                state  <= S_IDLE;
              end else begin
                rd_idx <= rd_idx + 1'b1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
